// File: rtl/stump_trace_pkg.sv
// stump_trace_pkg
// Shared definitions for the Stump bus trace buffer.
// Contents:
//   - the kind encodings for captured events
//   - the stored entry layout (34 bits: kind, address, data)
//   - a helper that classifies one bus cycle into a kind
package stump_trace_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int KIND_W  = 2;
  localparam int ENTRY_W = KIND_W + ADDR_W + DATA_W;  // 34

  // 00 is never stored. The head outputs show it only while the FIFO is empty.
  typedef enum logic [KIND_W-1:0] {
    KIND_NONE  = 2'b00,
    KIND_FETCH = 2'b01,
    KIND_READ  = 2'b10,
    KIND_WRITE = 2'b11
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e       kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } trace_entry_t;

  // A write wins over a read in the same cycle.
  // A read is a fetch only when the fetch qualifier is set.
  function automatic trace_kind_e classify(input logic wen, input logic fetch);
    if (wen)        return KIND_WRITE;
    else if (fetch) return KIND_FETCH;
    else            return KIND_READ;
  endfunction

endpackage

// File: rtl/stump_trace_fifo.sv
// stump_trace_fifo
// Synchronous first-word-fall-through FIFO with an optional overwrite-oldest mode.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   clear                empties the FIFO and clears overflow; wins over push and pop
//   push, push_data      write request and the word to write
//   pop                  consume the head; ignored while empty
//   wrap                 1 = when full, a push without a pop replaces the oldest entry
//   valid, head_data     FIFO not empty, and the head word (0 while empty)
//   count                number of entries held, 0..DEPTH
//   overflow             sticky: a push was dropped or overwrote an entry
// DEPTH must be a power of two, so the pointers wrap without extra logic.
module stump_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 34
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       wrap,
  output logic                       valid,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  logic empty, full, pop_ok;
  logic do_write, do_overwrite, rptr_adv, cnt_inc, cnt_dec;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign pop_ok = pop & ~empty;

  // When the FIFO is full, a push is accepted only if a pop happens in the
  // same cycle or wrap is set. With wrap set and no pop, the write lands on
  // the oldest slot (wptr == rptr while full), so the read pointer steps past it.
  always_comb begin
    do_write     = 1'b0;
    do_overwrite = 1'b0;
    if (push) begin
      if (!full || pop_ok) begin
        do_write = 1'b1;
      end else if (wrap) begin
        do_write     = 1'b1;
        do_overwrite = 1'b1;
      end
    end
  end

  assign rptr_adv = pop_ok | do_overwrite;
  assign cnt_inc  = do_write & ~do_overwrite & ~pop_ok;
  assign cnt_dec  = pop_ok & ~do_write;

  // The storage array has no reset. Its contents are only seen through the
  // valid gate on the head.
  always_ff @(posedge clk) begin
    if (!rst && !clear && do_write)
      mem[wptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_write) wptr_q <= wptr_q + AW'(1);
      if (rptr_adv) rptr_q <= rptr_q + AW'(1);
      if (cnt_inc)
        count_q <= count_q + CW'(1);
      else if (cnt_dec)
        count_q <= count_q - CW'(1);
      // A push that is dropped or that overwrites an entry marks overflow.
      if (push && full && !pop_ok)
        ovf_q <= 1'b1;
    end
  end

  assign valid     = ~empty;
  assign head_data = empty ? '0 : mem[rptr_q];
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/stump_trace_buffer.sv
// stump_trace_buffer
// Passive trace tap on the Stump memory bus. It classifies each bus cycle and
// queues it into a FIFO that a host drains.
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   mem_ren, mem_wen, fetch      Stump bus strobes; fetch qualifies a read
//   address, data_in, data_out   bus address, read data returned to Stump,
//                                and write data from Stump
//   trace_en, fetch_only, wrap   capture controls
//   clear, pop                   host controls
//   trace_valid, trace_kind,
//   trace_addr, trace_data       head entry (all 0 while empty)
//   count, overflow              fill level, and a sticky flag for dropped
//                                or overwritten events
module stump_trace_buffer
  import stump_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_ren,
  input  logic                   mem_wen,
  input  logic                   fetch,
  input  logic [15:0]            address,
  input  logic [15:0]            data_in,
  input  logic [15:0]            data_out,
  input  logic                   trace_en,
  input  logic                   fetch_only,
  input  logic                   wrap,
  input  logic                   clear,
  input  logic                   pop,
  output logic                   trace_valid,
  output logic [1:0]             trace_kind,
  output logic [15:0]            trace_addr,
  output logic [15:0]            trace_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  trace_kind_e  ev_kind;
  trace_entry_t ev_entry;
  trace_entry_t head;
  logic         ev_hit, ev_keep, ev_push;
  logic [ENTRY_W-1:0] head_bits;

  // Capture is purely combinational into the FIFO write port. An event seen
  // at an edge therefore appears on the head right after that edge.
  always_comb begin
    ev_kind       = classify(mem_wen, fetch);
    ev_entry.kind = ev_kind;
    ev_entry.addr = address;
    ev_entry.data = (ev_kind == KIND_WRITE) ? data_out : data_in;
  end

  assign ev_hit  = trace_en & (mem_ren | mem_wen);
  // With fetch_only set, reads and writes are filtered out before the FIFO,
  // so they never count as drops.
  assign ev_keep = ~fetch_only | (ev_kind == KIND_FETCH);
  assign ev_push = ev_hit & ev_keep;

  stump_trace_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (ev_push),
    .push_data (ev_entry),
    .pop       (pop),
    .wrap      (wrap),
    .valid     (trace_valid),
    .head_data (head_bits),
    .count     (count),
    .overflow  (overflow)
  );

  // The FIFO already forces head_bits to 0 while empty.
  assign head       = trace_entry_t'(head_bits);
  assign trace_kind = head.kind;
  assign trace_addr = head.addr;
  assign trace_data = head.data;

endmodule

// File: tb/tb_stump_trace_buffer.sv
module tb_stump_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, mem_ren, mem_wen, fetch, trace_en, fetch_only, wrap, clear, pop;
  logic [15:0]   address, data_in, data_out;
  logic          trace_valid, overflow;
  logic [1:0]    trace_kind;
  logic [15:0]   trace_addr, trace_data;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  // Reference state: a queue of {kind, addr, data} plus the sticky overflow bit.
  logic [33:0] mq[$];
  bit          m_ovf;

  always #5 clk = ~clk;

  stump_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen), .fetch(fetch),
    .address(address), .data_in(data_in), .data_out(data_out),
    .trace_en(trace_en), .fetch_only(fetch_only), .wrap(wrap), .clear(clear), .pop(pop),
    .trace_valid(trace_valid), .trace_kind(trace_kind), .trace_addr(trace_addr),
    .trace_data(trace_data), .count(count), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one clock edge of the behavioural rules to the queue.
  task automatic model_step();
    logic [33:0] e;
    bit hit, keep, pop_ok;
    if (rst || clear) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      hit = trace_en && (mem_ren || mem_wen);
      if (mem_wen)    e = {2'b11, address, data_out};
      else if (fetch) e = {2'b01, address, data_in};
      else            e = {2'b10, address, data_in};
      keep   = !fetch_only || (e[33:32] == 2'b01);
      pop_ok = pop && (mq.size() > 0);
      if (pop_ok) void'(mq.pop_front());
      if (hit && keep) begin
        if (mq.size() < DEPTH) mq.push_back(e);
        else if (wrap) begin
          void'(mq.pop_front());
          mq.push_back(e);
          m_ovf = 1'b1;
        end else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_model();
    logic [33:0] h;
    h = (mq.size() > 0) ? mq[0] : 34'd0;
    chk("m_valid", 32'(trace_valid), 32'(mq.size() > 0));
    chk("m_kind",  32'(trace_kind),  32'(h[33:32]));
    chk("m_addr",  32'(trace_addr),  32'(h[31:16]));
    chk("m_data",  32'(trace_data),  32'(h[15:0]));
    chk("m_count", 32'(count),       32'(mq.size()));
    chk("m_ovf",   32'(overflow),    32'(m_ovf));
  endtask

  // One clock: the model samples the inputs at the edge, and the outputs are
  // compared 1 ns later. Callers change the inputs after the task returns.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic idle();
    mem_ren = 0; mem_wen = 0; fetch = 0; clear = 0; pop = 0;
    address = 0; data_in = 0; data_out = 0;
  endtask

  task automatic set_ev(input bit ren, input bit wen, input bit f,
                        input logic [15:0] a, input logic [15:0] din, input logic [15:0] dout);
    mem_ren = ren; mem_wen = wen; fetch = f;
    address = a; data_in = din; data_out = dout;
  endtask

  initial begin
    rst = 1; trace_en = 0; fetch_only = 0; wrap = 0;
    idle();
    cyc(); cyc();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(trace_valid), 0);
    chk("rst_ovf",   32'(overflow), 0);
    chk("rst_head",  {14'd0, trace_kind, trace_addr}, 0);
    rst = 0; trace_en = 1;

    // Single fetch, visible right after the edge.
    set_ev(1, 0, 1, 16'h0010, 16'hA5A5, 16'h0000);
    cyc(); idle();
    chk("fetch_valid", 32'(trace_valid), 1);
    chk("fetch_kind",  32'(trace_kind), 1);
    chk("fetch_addr",  32'(trace_addr), 32'h0010);
    chk("fetch_data",  32'(trace_data), 32'hA5A5);
    chk("fetch_count", 32'(count), 1);

    // Read and write in the same cycle: the write takes priority.
    set_ev(1, 1, 1, 16'h8000, 16'hDEAD, 16'h1234);
    cyc(); idle();
    // Disabled capture is ignored.
    trace_en = 0; set_ev(1, 0, 0, 16'h4444, 16'h1111, 0);
    cyc(); idle(); trace_en = 1;
    chk("dis_count", 32'(count), 2);
    pop = 1; cyc(); idle();
    chk("both_kind", 32'(trace_kind), 3);
    chk("both_data", 32'(trace_data), 32'h1234);
    chk("both_addr", 32'(trace_addr), 32'h8000);
    clear = 1; cyc(); idle();

    // wrap=0: DEPTH+1 writes, so the last one is dropped.
    for (int i = 0; i <= DEPTH; i++) begin
      set_ev(0, 1, 0, 16'(i), 0, 16'(i) ^ 16'h5A00);
      cyc();
    end
    idle(); cyc();
    chk("nowrap_count", 32'(count), DEPTH);
    chk("nowrap_ovf",   32'(overflow), 1);
    chk("nowrap_head",  32'(trace_addr), 0);
    // Toggling the controls must leave the stored entries untouched.
    trace_en = 0; fetch_only = 1; wrap = 1; cyc();
    trace_en = 1; fetch_only = 0; wrap = 0; cyc();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("nowrap_last", 32'(trace_addr), DEPTH - 1);
      pop = 1; cyc();
    end
    idle();
    chk("nowrap_empty", 32'(count), 0);
    chk("nowrap_ovf_sticky", 32'(overflow), 1);
    clear = 1; cyc(); idle();
    chk("clear_ovf", 32'(overflow), 0);

    // wrap=1: DEPTH+2 events, so the two oldest are overwritten.
    wrap = 1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      set_ev(1, 0, 0, 16'(i), 16'(i) + 16'h0100, 0);
      cyc();
    end
    idle();
    chk("wrap_count", 32'(count), DEPTH);
    chk("wrap_ovf",   32'(overflow), 1);
    chk("wrap_head",  32'(trace_addr), 2);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("wrap_last", 32'(trace_addr), DEPTH + 1);
      pop = 1; cyc();
    end
    idle(); wrap = 0;
    clear = 1; cyc(); idle();

    // Full FIFO with a push and a pop in the same cycle.
    for (int i = 0; i < DEPTH; i++) begin
      set_ev(1, 0, 1, 16'(i), 16'(i), 0);
      cyc();
    end
    set_ev(1, 0, 1, 16'h0100, 16'h0BEE, 0); pop = 1;
    cyc(); idle();
    chk("fullpp_count", 32'(count), DEPTH);
    chk("fullpp_ovf",   32'(overflow), 0);
    chk("fullpp_head",  32'(trace_addr), 1);
    // Clear wins over a coincident push.
    set_ev(0, 1, 0, 16'h0200, 0, 16'h0202); clear = 1;
    cyc(); idle();
    chk("clrpush_count", 32'(count), 0);
    chk("clrpush_valid", 32'(trace_valid), 0);

    // fetch_only: a data read is filtered, a fetch is kept.
    fetch_only = 1;
    set_ev(1, 0, 0, 16'h0200, 16'h2222, 0); cyc();
    set_ev(1, 0, 1, 16'h0300, 16'h3333, 0); cyc();
    set_ev(0, 1, 0, 16'h0400, 0, 16'h4444); cyc();
    idle(); fetch_only = 0;
    chk("fo_count", 32'(count), 1);
    chk("fo_addr",  32'(trace_addr), 32'h0300);
    chk("fo_kind",  32'(trace_kind), 1);
    chk("fo_ovf",   32'(overflow), 0);
    pop = 1; cyc();
    pop = 1; cyc(); idle();
    chk("popempty_count", 32'(count), 0);

    // Reset mid-operation overrides everything. Capture resumes afterwards.
    for (int i = 0; i < 3; i++) begin
      set_ev(1, 0, 0, 16'(16'h0500 + i), 16'(i), 0); cyc();
    end
    rst = 1; pop = 1; clear = 1; cyc();
    rst = 0; idle();
    chk("midrst_count", 32'(count), 0);
    set_ev(1, 0, 1, 16'h0600, 16'h6666, 0); cyc(); idle();
    chk("resume_count", 32'(count), 1);
    chk("resume_data",  32'(trace_data), 32'h6666);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stump_trace_buffer.md
STUMP_TRACE_BUFFER -- requirements
Module: stump_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries (power of two, 4..64).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset: synchronous, active-high.
REQ-004 mem_ren  input  1  Stump read-enable.
REQ-005 mem_wen  input  1  Stump write-enable.
REQ-006 fetch  input  1  Stump fetch indicator, qualifies mem_ren.
REQ-007 address  input  16  Stump memory address.
REQ-008 data_in  input  16  data returned to Stump.
REQ-009 data_out  input  16  data written by Stump.
REQ-010 trace_en  input  1  capture enable.
REQ-011 fetch_only  input  1  capture instruction fetches only.
REQ-012 wrap  input  1  1 = overwrite oldest when full; 0 = stop when full.
REQ-013 clear  input  1  empty FIFO, clear overflow.
REQ-014 pop  input  1  host consumes head entry.
REQ-015 trace_valid  output  1  FIFO non-empty; head outputs meaningful.
REQ-016 trace_kind  output  2  head kind: 01 fetch, 10 data read, 11 write.
REQ-017 trace_addr  output  16  head address.
REQ-018 trace_data  output  16  head data.
REQ-019 count  output  log2(DEPTH)+1  entries held, 0..DEPTH.
REQ-020 overflow  output  1  sticky: at least one event dropped or overwritten.

Function
REQ-021 Event exists in a cycle when trace_en=1 and (mem_ren=1 or mem_wen=1).
REQ-022 Kind: mem_wen=1 -> 11 (priority when both asserted); else mem_ren&fetch -> 01; else mem_ren&~fetch -> 10.
REQ-023 Data: kind 11 captures data_out; kinds 01/10 capture data_in; address captured unchanged.
REQ-024 fetch_only=1 suppresses kinds 10 and 11; they are not counted as drops.
REQ-025 Push latency 1: event sampled at edge N is visible on head outputs after edge N when FIFO was empty (first-word fall-through).
REQ-026 pop with trace_valid=1 advances head at next edge; pop with trace_valid=0 ignored, no state change.
REQ-027 Simultaneous push and pop, not full: both performed, count unchanged.
REQ-028 Simultaneous push and pop when full: both performed, no overflow, count stays DEPTH.
REQ-029 Push when full, no pop, wrap=0: event dropped, FIFO unchanged, overflow set.
REQ-030 Push when full, no pop, wrap=1: oldest discarded, new entry written at tail, count stays DEPTH, overflow set.
REQ-031 clear has priority over push and pop in the same cycle: after edge count=0, trace_valid=0, overflow=0; the coincident event is discarded.
REQ-032 Read/write pointers wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-033 Head outputs hold stable while trace_valid=1 and pop=0; undefined-free (driven 0) when empty.
REQ-034 Toggling trace_en, fetch_only or wrap never alters stored entries.

Reset
REQ-035 rst=1 at an edge: count=0, trace_valid=0, overflow=0, trace_kind/addr/data=0, pointers=0; overrides clear, push, pop.
REQ-036 Reset mid-operation discards all entries; capture resumes the cycle after rst deasserts.
REQ-037 Storage array contents need not be reset; outputs gated by trace_valid.

Structure
REQ-038 Package stump_trace_pkg holds kind encodings (KIND_FETCH=01, KIND_READ=10, KIND_WRITE=11) and entry width 34.
REQ-039 One sub-module stump_trace_fifo: synchronous FIFO with DEPTH parameter, push/pop/clear, overwrite-oldest option; capture/classification logic stays in top.
REQ-040 Instantiated in the system wrapper beside the debugger, tapping the Stump bus nets non-intrusively.

Verification
REQ-041 Reset, trace_en=1, fetch read addr 0x0010 data 0xA5A5 -> next cycle trace_valid=1, kind 01, addr 0x0010, data 0xA5A5, count=1.
REQ-042 mem_ren=1 and mem_wen=1 same cycle, addr 0x8000, data_out 0x1234 -> entry kind 11, data 0x1234.
REQ-043 wrap=0, push DEPTH+1 writes addr 0..DEPTH -> count=DEPTH, overflow=1, head addr 0, addr DEPTH absent.
REQ-044 wrap=1, push DEPTH+2 events addr 0..DEPTH+1 -> count=DEPTH, overflow=1, head addr 2, last popped addr DEPTH+1.
REQ-045 FIFO full, push and pop same cycle -> count=DEPTH, overflow=0, head advances by one; clear with push same cycle -> count=0.
REQ-046 fetch_only=1, data read then fetch -> only fetch recorded; pop while empty -> count stays 0.
